spi_burst_ctrl: RTL and testbench

Sequencer and two-way arbiter for the byte-wide SPI shift engine. It grants the engine to one of two requesters, e.g. the CPU port and the boot/DMA port. For the granted requester it runs a burst of 1..2^LEN_W bytes: it drives the engine's load/unload strobes, holds a burst-wide chip select, and returns each received byte. It sits between the SoC bus-side requesters and the SPI engine instance.

---
 rtl/spi_burst_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_spi_burst_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: two-way round-robin arbiter and burst sequencer for a
// byte-wide SPI shift engine. Holds a burst-wide chip select, strobes the
// engine's load/unload inputs and returns each received byte.
//
// Build option: define SPI_BURST_TMO_EN to add a SHIFT-phase watchdog that
// aborts a burst (done+err) after TMO_CYC cycles without the engine finishing.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; arbitrate between req0/req1
// LOAD    | one cycle: load owner's txd into the engine, pulse tx_rdy
// SHIFT   | engine shifting; unload the cycle spi_ssn_out returns high
// CAPTURE | one cycle: present received byte, step byte counter
// DONE    | one cycle: burst complete, release grant
// ABORT   | one cycle: watchdog expired (SPI_BURST_TMO_EN only)
module spi_burst_ctrl #(
  parameter int LEN_W   = 4,
  parameter int TMO_CYC = 15
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       txd0,
  input  logic [7:0]       txd1,
  output logic [1:0]       grant,
  output logic             tx_rdy,
  output logic [7:0]       rxd,
  output logic             rx_vld,
  output logic             done,
  output logic             err,
  output logic             cs_n,
  output logic             spi_load,
  output logic             spi_unload,
  output logic [7:0]       spi_datain,
  input  logic [7:0]       spi_dataout,
  input  logic             spi_ssn_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4,
    S_ABORT   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               cs_n_q, cs_n_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;   // 1 = req1 owned the previous burst
  logic [7:0]         rxd_q, rxd_d;
  logic               pick1;

`ifdef SPI_BURST_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  logic [TMO_W-1:0]   tmo_q, tmo_d;
`endif

  // Round-robin pick: a lone requester wins; on contention the one not served last.
  assign pick1 = req1 & (~req0 | ~last_q);

  // State register and datapath flops, synchronous reset.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      cs_n_q  <= 1'b1;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      rxd_q   <= 8'h00;
`ifdef SPI_BURST_TMO_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cs_n_q  <= cs_n_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rxd_q   <= rxd_d;
`ifdef SPI_BURST_TMO_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Next-state and next-datapath computation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cs_n_d  = cs_n_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    rxd_d   = rxd_q;
`ifdef SPI_BURST_TMO_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          cnt_d   = pick1 ? len1 : len0;
          cs_n_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef SPI_BURST_TMO_EN
        tmo_d   = '0;
`endif
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (spi_ssn_out) begin
          state_d = S_CAPTURE;
        end
`ifdef SPI_BURST_TMO_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_ABORT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_CAPTURE: begin
        rxd_d = spi_dataout;
        if (cnt_q == '0) begin
          // Chip select rises as the burst ends so it is high during DONE.
          cs_n_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        // Grant stays visible alongside done so the owner can match it.
        grant_d = 2'b00;
        last_d  = grant_q[1];
        state_d = S_IDLE;
      end
      S_ABORT: begin
        grant_d = 2'b00;
        cs_n_d  = 1'b1;
        last_d  = grant_q[1];
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore strobes plus the combinational unload, which must land in the
  // same cycle the engine signals completion.
  always_comb begin
    tx_rdy     = (state_q == S_LOAD);
    spi_load   = (state_q == S_LOAD);
    spi_unload = (state_q == S_SHIFT) & spi_ssn_out;
    rx_vld     = (state_q == S_CAPTURE);
    done       = (state_q == S_DONE) | (state_q == S_ABORT);
`ifdef SPI_BURST_TMO_EN
    err        = (state_q == S_ABORT);
`else
    err        = 1'b0;
`endif
    // The engine latch is stable through CAPTURE, so the byte is shown
    // together with rx_vld and held in rxd_q afterwards.
    rxd        = (state_q == S_CAPTURE) ? spi_dataout : rxd_q;
    if (grant_q[0]) begin
      spi_datain = txd0;
    end else if (grant_q[1]) begin
      spi_datain = txd1;
    end else begin
      spi_datain = 8'h00;
    end
  end

  assign grant = grant_q;
  assign cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a loopback engine stub.
module tb_spi_burst_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] len0 = 4'd0, len1 = 4'd0;
  logic [7:0] txd0 = 8'h00, txd1 = 8'h00;
  logic [1:0] grant;
  logic       tx_rdy, rx_vld, done, err, cs_n, spi_load, spi_unload;
  logic [7:0] rxd, spi_datain, spi_dataout;
  logic       spi_ssn_out;

  int nvec = 0;
  int nerr = 0;

  // Engine stub: 8-cycle shift after load, receive latch loops mosi to miso.
  logic [3:0] eng_cnt = 4'd0;
  logic [7:0] eng_sh  = 8'h00;
  logic [7:0] eng_out = 8'h00;
  logic       stall   = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (spi_load) begin
      eng_sh  <= spi_datain;
      eng_cnt <= 4'd8;
    end else if (eng_cnt != 4'd0) begin
      eng_cnt <= eng_cnt - 4'd1;
    end
    if (spi_unload) eng_out <= eng_sh;
  end

  assign spi_ssn_out = stall ? 1'b0 : (eng_cnt <= 4'd1);
  assign spi_dataout = eng_out;

  spi_burst_ctrl #(.LEN_W(4), .TMO_CYC(15)) dut (
    .clock_in    (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .len0        (len0),
    .len1        (len1),
    .txd0        (txd0),
    .txd1        (txd1),
    .grant       (grant),
    .tx_rdy      (tx_rdy),
    .rxd         (rxd),
    .rx_vld      (rx_vld),
    .done        (done),
    .err         (err),
    .cs_n        (cs_n),
    .spi_load    (spi_load),
    .spi_unload  (spi_unload),
    .spi_datain  (spi_datain),
    .spi_dataout (spi_dataout),
    .spi_ssn_out (spi_ssn_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int nrx;
    int done_c;

    // Reset state
    step(); step();
    chk("rst_grant", grant, 2'b00);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_rxd", rxd, 8'h00);
    chk("rst_strobes", {rx_vld, tx_rdy, done, err, spi_load, spi_unload}, 6'b0);
    chk("rst_datain", spi_datain, 8'h00);
    reset = 1'b0;

    // Single byte, loopback: tx_rdy@1, unload@9, rx_vld@10, done@11
    req0 = 1'b1; len0 = 4'd0; txd0 = 8'hA5;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("t1_tx_rdy", tx_rdy, (c == 1));
      chk("t1_load", spi_load, (c == 1));
      chk("t1_unload", spi_unload, (c == 9));
      chk("t1_rx_vld", rx_vld, (c == 10));
      chk("t1_done", done, (c == 11));
      chk("t1_err", err, 1'b0);
      chk("t1_cs_n", cs_n, !(c >= 1 && c <= 10));
      chk("t1_grant", grant, (c <= 11) ? 2'b01 : 2'b00);
      if (c == 1) begin
        chk("t1_datain", spi_datain, 8'hA5);
        req0 = 1'b0;
      end
      if (c == 10) chk("t1_rxd", rxd, 8'hA5);
      if (c == 12) chk("t1_rxd_hold", rxd, 8'hA5);
    end

    // Round-robin from reset: 01, 10, 01
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd0; len1 = 4'd0;
    txd0 = 8'h3C; txd1 = 8'hC3;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("t2_grant_a", grant, 2'b01);
    chk("t2_datain_a", spi_datain, 8'h3C);
    repeat (10) step();
    chk("t2_done_a", {done, grant}, 3'b101);
    step();
    chk("t2_gap", grant, 2'b00);
    step();
    chk("t2_grant_b", grant, 2'b10);
    chk("t2_datain_b", spi_datain, 8'hC3);
    repeat (12) step();
    chk("t2_grant_c", grant, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    repeat (11) step();
    chk("t2_idle", {grant, cs_n}, 3'b001);

    // Three-byte burst from req1 with txd stepping on consumption
    req1 = 1'b1; len1 = 4'd2; txd1 = 8'h11;
    for (int c = 1; c <= 32; c++) begin
      step();
      chk("t3_tx_rdy", tx_rdy, (c == 1 || c == 11 || c == 21));
      chk("t3_rx_vld", rx_vld, (c == 10 || c == 20 || c == 30));
      chk("t3_done", done, (c == 31));
      chk("t3_cs_n", cs_n, !(c >= 1 && c <= 30));
      if (c == 1) req1 = 1'b0;
      if (c == 2) txd1 = 8'h22;
      if (c == 12) txd1 = 8'h33;
      if (c == 10) chk("t3_rxd0", rxd, 8'h11);
      if (c == 20) chk("t3_rxd1", rxd, 8'h22);
      if (c == 30) chk("t3_rxd2", rxd, 8'h33);
      if (c == 31) chk("t3_grant", grant, 2'b10);
    end

    // Reset during SHIFT of byte 2, then a fresh burst
    req0 = 1'b1; len0 = 4'd2; txd0 = 8'h5A;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) req0 = 1'b0;
      chk("t4_no_done", done, 1'b0);
    end
    reset = 1'b1;
    step();
    chk("t4_rst_grant", grant, 2'b00);
    chk("t4_rst_cs_n", cs_n, 1'b1);
    chk("t4_rst_strobes", {done, rx_vld, tx_rdy, spi_load}, 4'b0);
    reset = 1'b0;
    req0 = 1'b1; len0 = 4'd0; txd0 = 8'h77;
    step();
    chk("t4_regrant", {grant, tx_rdy, cs_n}, 4'b0110);
    req0 = 1'b0;
    repeat (9) step();
    chk("t4_rx", {rx_vld, rxd}, {1'b1, 8'h77});
    step();
    chk("t4_done", done, 1'b1);
    step();

    // Engine stuck busy
    stall = 1'b1;
    req0 = 1'b1; len0 = 4'd0; txd0 = 8'h99;
`ifdef SPI_BURST_TMO_EN
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 1) req0 = 1'b0;
      chk("t5_done", done, (c == 17));
      chk("t5_err", err, (c == 17));
      chk("t5_rx_vld", rx_vld, 1'b0);
      chk("t5_cs_n", cs_n, !(c >= 1 && c <= 17));
    end
    chk("t5_grant", grant, 2'b00);
    stall = 1'b0;
`else
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1) req0 = 1'b0;
      chk("t5_hold", {done, err, cs_n, rx_vld}, 4'b0);
    end
    stall = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_recover", {grant, cs_n}, 3'b001);
`endif
    step();

    // Maximum length: 16 bytes, done at cycle 10*16+1
    req0 = 1'b1; len0 = 4'hF; txd0 = 8'hE1;
    nrx = 0;
    done_c = 0;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (c == 1) req0 = 1'b0;
      if (rx_vld) nrx++;
      if (done) begin
        done_c = c;
        break;
      end
    end
    chk("t6_rx_count", nrx[15:0], 16'd16);
    chk("t6_done_cycle", done_c[15:0], 16'd161);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
